// File: rtl/arg_calc_pkg.sv
// Shared types and helpers for argument_calc_multi.
// ARG_SYMMETRIC_RANGE_EN selects the output range returned by lo_bound/hi_bound.
package arg_calc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam longint TWO_PI_DEF = 64'sd6283185;

`ifdef ARG_SYMMETRIC_RANGE_EN
  localparam bit RANGE_SYM = 1'b1;
`else
  localparam bit RANGE_SYM = 1'b0;
`endif

  function automatic longint lo_bound(input longint two_pi);
    return RANGE_SYM ? -(two_pi / 64'sd2) : 64'sd0;
  endfunction

  function automatic longint hi_bound(input longint two_pi);
    return lo_bound(two_pi) + two_pi;
  endfunction

  // Arithmetic shift rounds toward -inf; biasing negatives first gives round-toward-zero.
  function automatic logic signed [127:0] trunc0_shift(input logic signed [127:0] x,
                                                       input int sh);
    logic signed [127:0] bias;
    bias = x[127] ? ((128'sd1 <<< sh) - 128'sd1) : 128'sd0;
    return (x + bias) >>> sh;
  endfunction

endpackage

// File: rtl/arg_store_rf.sv
// Per-channel argument store: NCH x W, one synchronous write port,
// one combinational read port, asynchronous active-low clear.
module arg_store_rf #(
  parameter int W    = 64,
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [CH_W-1:0] waddr,
  input  logic [W-1:0]    wdata,
  input  logic [CH_W-1:0] raddr,
  output logic [W-1:0]    rdata
);

  logic [W-1:0] mem [NCH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/argument_calc_multi.sv
// argument_calc_multi: theta (or stored channel argument) + delta/2^DELTA_SHIFT, wrapped
// into one turn. Define ARG_SYMMETRIC_RANGE_EN for the [-TWO_PI/2, TWO_PI/2) range.
module argument_calc_multi
  import arg_calc_pkg::*;
#(
  parameter int     W           = 64,
  parameter int     NCH         = 4,
  parameter int     CH_W        = 2,
  parameter longint TWO_PI      = TWO_PI_DEF,
  parameter int     DELTA_SHIFT = 1,
  parameter int     MAX_ITER    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_chan,
  input  logic                acc_mode,
  input  logic signed [W-1:0] theta,
  input  logic signed [W-1:0] delta_theta,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_chan,
  output logic signed [W-1:0] argument,
  output logic                out_err,
  output logic [1:0]          dbg_state
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic signed [W:0] LO       = (W+1)'(lo_bound(TWO_PI));
  localparam logic signed [W:0] HI       = (W+1)'(hi_bound(TWO_PI));
  localparam logic signed [W:0] TWO_PI_X = (W+1)'(TWO_PI);

  state_t              state;
  logic signed [W:0]   q;
  logic [CH_W-1:0]     chan_q;
  logic [ITER_W-1:0]   iter;
  logic signed [W-1:0] rd_data;
  logic signed [W-1:0] base;
  logic signed [W:0]   q_in;
  logic                q_low;
  logic                q_high;
  logic                store_we;

  assign dbg_state = state;

  // W+1 bits so base + shifted delta cannot overflow before wrapping.
  assign base     = acc_mode ? rd_data : theta;
  assign q_in     = (W+1)'(base) + (W+1)'(trunc0_shift(128'(delta_theta), DELTA_SHIFT));
  assign q_low    = (q < LO);
  assign q_high   = (q >= HI);
  assign store_we = (state == S_NORM) && !q_low && !q_high;

  arg_store_rf #(.W(W), .NCH(NCH), .CH_W(CH_W)) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (store_we),
    .waddr (chan_q),
    .wdata (q[W-1:0]),
    .raddr (in_chan),
    .rdata (rd_data)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // out_valid, argument, out_chan and out_err stay put until that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      argument  <= '0;
      out_chan  <= '0;
      q         <= '0;
      chan_q    <= '0;
      iter      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            q        <= q_in;
            chan_q   <= in_chan;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= S_NORM;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_NORM: begin
          if (q_low || q_high) begin
            if (iter == ITER_W'(MAX_ITER)) begin
              argument  <= '0;
              out_err   <= 1'b1;
              out_chan  <= chan_q;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              q    <= q_low ? (q + TWO_PI_X) : (q - TWO_PI_X);
              iter <= iter + 1'b1;
            end
          end else begin
            argument  <= q[W-1:0];
            out_err   <= 1'b0;
            out_chan  <= chan_q;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argument_calc_multi.sv
// Directed bench for argument_calc_multi (MAX_ITER=4, other parameters at defaults).
module tb_argument_calc_multi;

  localparam int     W   = 64;
  localparam longint TP  = 64'sd6283185;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_chan;
  logic                acc_mode;
  logic signed [W-1:0] theta;
  logic signed [W-1:0] delta_theta;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_chan;
  logic signed [W-1:0] argument;
  logic                out_err;
  logic [1:0]          dbg_state;

  int n_vec;
  int n_bad;
  logic [W-1:0] exp_q[$];

  argument_calc_multi #(
    .W(W), .NCH(4), .CH_W(2), .TWO_PI(TP), .DELTA_SHIFT(1), .MAX_ITER(4)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .acc_mode(acc_mode), .theta(theta), .delta_theta(delta_theta),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .argument(argument), .out_err(out_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // lat = rising edges from the accept edge to the first edge that sees out_valid=1.
  task automatic run_req(input logic [1:0] ch, input logic acc, input longint th,
                         input longint dt, output int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      lat = -1;
      return;
    end
    in_chan = ch; acc_mode = acc; theta = th; delta_theta = dt; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_req();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out_err: got %0b want 0", out_err); end
    n_vec++; if (argument !== 64'sd0) begin n_bad++; $display("FAIL rst_argument: got %0d want 0", argument); end
    n_vec++; if (out_chan !== 2'd0) begin n_bad++; $display("FAIL rst_out_chan: got %0d want 0", out_chan); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    exp_q.push_back(64'd2000000);
    run_req(2'd0, 1'b0, 1000000, 2000000, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL basic_arg: got %0d want 2000000", argument); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %0b want 0", out_err); end
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_busy: got %0b want 0", in_ready); end
    finish_req();
  endtask

`ifdef ARG_SYMMETRIC_RANGE_EN
  task automatic test_symmetric();
    int lat;
    exp_q.push_back(-64'sd2283185);
    run_req(2'd1, 1'b0, 4000000, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL sym_high_arg: got %0d want -2283185", argument); end
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL sym_high_latency: got %0d want 3", lat); end
    finish_req();
    exp_q.push_back(-64'sd3141592);
    run_req(2'd1, 1'b0, -3141592, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL sym_lo_edge: got %0d want -3141592", argument); end
    finish_req();
  endtask
`else
  task automatic test_wrap();
    int lat;
    exp_q.push_back(64'd6283085);
    run_req(2'd1, 1'b0, -100, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL wrap_low_arg: got %0d want 6283085", argument); end
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL wrap_low_latency: got %0d want 3", lat); end
    finish_req();
    exp_q.push_back(64'd0);
    run_req(2'd1, 1'b0, TP, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL wrap_hi_edge: got %0d want 0", argument); end
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL wrap_hi_latency: got %0d want 3", lat); end
    finish_req();
  endtask
`endif

  task automatic test_trunc();
    int lat;
    longint e;
`ifdef ARG_SYMMETRIC_RANGE_EN
    e = -1;
`else
    e = 6283184;
`endif
    exp_q.push_back(e);
    run_req(2'd0, 1'b0, 0, -3, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL trunc_neg3: got %0d want %0d", argument, e); end
    finish_req();
    exp_q.push_back(64'd11);
    run_req(2'd0, 1'b0, 10, 3, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL trunc_pos3: got %0d want 11", argument); end
    finish_req();
    exp_q.push_back(64'd8);
    run_req(2'd0, 1'b0, 10, -4, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL trunc_neg4: got %0d want 8", argument); end
    finish_req();
  endtask

  task automatic test_acc();
    int lat;
    longint e;
`ifdef ARG_SYMMETRIC_RANGE_EN
    e = -283185;
`else
    e = 6000000;
`endif
    exp_q.push_back(e);
    run_req(2'd2, 1'b0, 6000000, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL acc_load: got %0d want %0d", argument, e); end
    finish_req();
    exp_q.push_back(64'd216815);
    run_req(2'd2, 1'b1, 999, 1000000, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL acc_ch2: got %0d want 216815", argument); end
    n_vec++; if (out_chan !== 2'd2) begin n_bad++; $display("FAIL acc_chan: got %0d want 2", out_chan); end
    finish_req();
    exp_q.push_back(64'd0);
    run_req(2'd3, 1'b1, 12345, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL acc_ch3_untouched: got %0d want 0", argument); end
    finish_req();
  endtask

  task automatic test_error();
    int lat;
    exp_q.push_back(64'd0);
    run_req(2'd2, 1'b0, 20 * TP, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL err_arg: got %0d want 0", argument); end
    n_vec++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %0b want 1", out_err); end
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL err_latency: got %0d want 6", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || argument !== 64'sd0 ||
          out_chan !== 2'd2 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold: valid=%0b err=%0b arg=%0d chan=%0d in_ready=%0b want 1 1 0 2 0",
                 out_valid, out_err, argument, out_chan, in_ready);
      end
    end
    finish_req();
    exp_q.push_back(64'd216815);
    run_req(2'd2, 1'b1, 0, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL err_store_kept: got %0d want 216815", argument); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %0b want 0", out_err); end
    finish_req();
  endtask

  task automatic test_back_to_back();
    int lat;
    int cyc;
    int n_acc;
    int a[2];
    exp_q.push_back(64'd105);
    run_req(2'd1, 1'b0, 100, 10, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL b2b_first: got %0d want 105", argument); end
    finish_req();
    exp_q.push_back(64'd115);
    run_req(2'd1, 1'b1, 0, 20, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL b2b_acc: got %0d want 115", argument); end
    finish_req();
    // Streaming: in_valid and out_ready held high, two +1 accumulations on channel 1.
    out_ready = 1'b1; in_chan = 2'd1; acc_mode = 1'b1; theta = 0; delta_theta = 2; in_valid = 1'b1;
    cyc = 0; n_acc = 0; a[0] = 0; a[1] = 0;
    while (n_acc < 2 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (in_ready) begin
        a[n_acc] = cyc;
        n_acc++;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    n_vec++; if (a[1] - a[0] !== 3) begin n_bad++; $display("FAIL b2b_throughput: got %0d want 3", a[1] - a[0]); end
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    exp_q.push_back(64'd117);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL b2b_stream: got %0d want 117", argument); end
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin @(negedge clk); waited++; end
    in_chan = 2'd0; acc_mode = 1'b0; theta = 20 * TP; delta_theta = 0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready: got %0b want 0", in_ready); end
    n_vec++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    @(negedge clk) reset = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_output: got %0b want 0", out_valid); end
    exp_q.push_back(64'd0);
    run_req(2'd2, 1'b1, 777, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL midrst_store2: got %0d want 0", argument); end
    finish_req();
    exp_q.push_back(64'd0);
    run_req(2'd1, 1'b1, 777, 0, lat);
    n_vec++; if (argument !== exp_q.pop_front()) begin n_bad++; $display("FAIL midrst_store1: got %0d want 0", argument); end
    finish_req();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; acc_mode = 1'b0;
    in_chan = '0; theta = '0; delta_theta = '0;
    test_reset();
    test_basic();
`ifdef ARG_SYMMETRIC_RANGE_EN
    test_symmetric();
`else
    test_wrap();
`endif
    test_trunc();
    test_acc();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/argument_calc_multi.md
Name: argument_calc_multi

Overview:
- Parametrised successor to the single-channel argument accumulator.
- Computes theta + delta_theta/2^DELTA_SHIFT for one of NCH channels and normalises the result into one full turn by iterative wrapping.
- Optionally accumulates onto a per-channel stored argument instead of an external theta.
- Uses valid/ready handshakes on input and output; sits between the angle-rate datapath and the trajectory/steering consumers.

Parameters:
- W, 64, signed width of theta, delta_theta and argument.
- NCH, 4, number of channels; also the depth of the per-channel argument store.
- CH_W, 2, channel index width; ceil(log2(NCH)), minimum 1.
- TWO_PI, 6283185, one full turn in microradians.
- DELTA_SHIFT, 1, delta divisor exponent; divide by 2^DELTA_SHIFT.
- MAX_ITER, 8, maximum wrap iterations before an error is reported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_chan  in  CH_W  channel index.
- acc_mode  in  1  1: use the stored channel argument instead of theta.
- theta  in  W  base angle, signed.
- delta_theta  in  W  angle change, signed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_chan  out  CH_W  channel of the result.
- argument  out  W  normalised angle, signed.
- out_err  out  1  wrap limit exceeded.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; in_ready=0 while reset is held.
  - out_valid=0, out_err=0, argument=0, out_chan=0.
  - All NCH store entries cleared to 0.
- Reset asserted mid-operation aborts the operation with no output.
- FSM states: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: compute base=acc_mode ? store[in_chan] : theta.
  - Compute q=base+trunc0(delta_theta/2^DELTA_SHIFT), with division truncating toward zero (e.g. -3/2 = -1).
  - Evaluate q in W+1 bits so it never overflows.
  - Register q, in_chan; clear iter; go to NORM.
- NORM (one step per cycle):
  - If q<LO: q+=TWO_PI.
  - Else if q>=HI: q-=TWO_PI.
  - Else: argument<=q[W-1:0], store[chan]<=q, out_err<=0; go to DONE.
  - Each wrap increments iter.
  - If iter==MAX_ITER and q is still out of range: argument<=0, out_err<=1, store unchanged; go to DONE.
  - Default range: LO=0, HI=TWO_PI.
- DONE:
  - out_valid=1; argument, out_chan and out_err held stable.
  - On out_valid&&out_ready: out_valid<=0; go to IDLE.
  - out_ready low stalls indefinitely.
- in_ready is 0 outside IDLE; only one request is in flight at a time.
- Latency from input accept edge to out_valid: 2 cycles + 1 per wrap. Best-case throughput: one result per 3 cycles.
- Store update is visible to the next request, including an acc_mode request to the same channel.
- in_chan>=NCH: treated as channel in_chan mod 2^CH_W. Illegal when NCH is not a power of two.

Optional Feature:
- Macro ARG_SYMMETRIC_RANGE_EN.
- Defined: LO=-(TWO_PI/2) (integer division), HI=LO+TWO_PI; default values give [-3141592, 3141593).
- Undefined: LO=0, HI=TWO_PI, giving [0, 6283185).
- Handshakes, latency rules and error behaviour are identical in both builds.

Decomposition:
- Package arg_calc_pkg: FSM state enum; default TWO_PI constant; range-bound functions lo_bound/hi_bound, selected by the macro; helper trunc0_shift for the delta divide.
- Natural sub-module: arg_store_rf, an NCH x W register file with one synchronous write port, one combinational read port and asynchronous active-low clear.

Test Plan (defaults unless stated):
- theta=1000000, delta=2000000, chan 0 -> argument=2000000, out_err=0, out_valid 2 cycles after accept.
- theta=-100, delta=0 -> argument=6283085 after 1 wrap, latency 3. theta=6283185, delta=0 -> argument=0.
- theta=0, delta=-3 -> q=-1 -> argument=6283184, confirming truncation toward zero.
- Channel 2 loaded with 6000000; then acc_mode=1, chan 2, delta=1000000 -> argument=216815. Channel 3 acc_mode with delta=0 -> 0 (untouched).
- MAX_ITER=4, theta=20*6283185 -> out_err=1, argument=0, store unchanged. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- Reset pulsed during NORM -> out_valid=0, store cleared. With ARG_SYMMETRIC_RANGE_EN: theta=4000000 -> argument=-2283185.
